popcount_seq_ctrl: RTL and testbench



---
 rtl/popcount_pkg.sv | 32 +++
 rtl/ones7_counter.sv | 34 +++
 rtl/popcount_seq_ctrl.sv | 118 +++++++++++
 tb/tb_popcount_seq_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared types, constants and helpers for the time-shared popcount sequencer.
//   state_t  : sequencer FSM states (IDLE, RUN, DONE)
//   CHUNK_W  : width of one chunk fed to the shared ones counter (7)
//   cw_of()  : result width needed to hold a count of 0..7*nchunk
//   fa_sum() / fa_carry() : 3-input ones counter (full adder) bits
// -----------------------------------------------------------------------------
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CHUNK_W = 7;

    function automatic int cw_of(input int nchunk);
        return $clog2(CHUNK_W * nchunk + 1);
    endfunction

    // Full adder viewed as a 3-input ones counter: {carry, sum} = a + b + c.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/ones7_counter.sv
// -----------------------------------------------------------------------------
// ones7_counter
// Purely combinational 7-bit to 3-bit ones counter built from full adders.
// Ports:
//   bits_i  [6:0]  input word
//   ones_o  [2:0]  number of set bits in bits_i (0..7)
// -----------------------------------------------------------------------------
module ones7_counter
    import popcount_pkg::*;
(
    input  logic [6:0] bits_i,
    output logic [2:0] ones_o
);

    // First level: two full adders compress bits 0..5 into two weight-1 sums
    // and two weight-2 carries.
    logic [1:0] lvl1_sum;
    logic [1:0] lvl1_carry;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl1
        assign lvl1_sum[gi]   = fa_sum  (bits_i[3*gi], bits_i[3*gi+1], bits_i[3*gi+2]);
        assign lvl1_carry[gi] = fa_carry(bits_i[3*gi], bits_i[3*gi+1], bits_i[3*gi+2]);
    end

    // Second level: the weight-1 sums plus bit 6 give the LSB and a third
    // weight-2 carry; the three weight-2 carries then give bits 1 and 2.
    logic lvl2_carry;

    assign ones_o[0]  = fa_sum  (lvl1_sum[0], lvl1_sum[1], bits_i[6]);
    assign lvl2_carry = fa_carry(lvl1_sum[0], lvl1_sum[1], bits_i[6]);
    assign ones_o[1]  = fa_sum  (lvl1_carry[0], lvl1_carry[1], lvl2_carry);
    assign ones_o[2]  = fa_carry(lvl1_carry[0], lvl1_carry[1], lvl2_carry);

endmodule

// File: rtl/popcount_seq_ctrl.sv
// -----------------------------------------------------------------------------
// popcount_seq_ctrl
// Population count of a DW = 7*NCHUNK bit word using one shared 7-bit ones
// counter, one chunk per clock, with a start/ready/busy/done handshake.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    request a count (accepted only while ready)
//   data_in  operand, sampled in the accepting cycle
//   ready    high in IDLE
//   busy     high while chunks are counted
//   done     one-cycle pulse when count is fresh
//   count    last completed result, held until the next completion
// Build option: define POPCOUNT_EARLY_EXIT_EN to finish as soon as the
// remaining (unshifted) chunks are all zero; otherwise latency is fixed.
// -----------------------------------------------------------------------------
module popcount_seq_ctrl
    import popcount_pkg::*;
#(
    parameter  int NCHUNK = 4,
    localparam int DW     = CHUNK_W * NCHUNK,
    localparam int CW     = cw_of(NCHUNK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t            state_q, state_d;
    logic [DW-1:0]     shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     count_q, count_d;

    logic [2:0]        chunk_ones;
    logic [DW-1:0]     shreg_shifted;
    logic [CW-1:0]     acc_sum;
    logic              last_chunk;

    ones7_counter u_ones7 (
        .bits_i (shreg_q[CHUNK_W-1:0]),
        .ones_o (chunk_ones)
    );

    assign shreg_shifted = shreg_q >> CHUNK_W;
    assign acc_sum       = acc_q + CW'(chunk_ones);

    always_comb begin
        last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
`ifdef POPCOUNT_EARLY_EXIT_EN
        // Nothing left to count once the remaining chunks are all zero.
        last_chunk = last_chunk || (shreg_shifted == '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = data_in;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                shreg_d = shreg_shifted;
                acc_d   = acc_sum;
                idx_d   = idx_q + IDX_W'(1);
                if (last_chunk) begin
                    // count includes this cycle's chunk, so use the sum, not acc_q.
                    count_d = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign count = count_q;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
module tb_popcount_seq_ctrl;

    localparam int NCHUNK = 4;
    localparam int DW     = 7 * NCHUNK;
    localparam int CW     = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] data_in;
    logic          ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;
    int model_count = 0;   // what count should hold between completions

    always #5 clk = ~clk;

    popcount_seq_ctrl #(.NCHUNK(NCHUNK)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            exp_count;
        bit            hold_start;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: bit count by plain arithmetic.
    function automatic int ref_ones(input logic [DW-1:0] d);
        int n = 0;
        for (int i = 0; i < DW; i++) n += int'(d[i]);
        return n;
    endfunction

    // Reference: cycle (relative to the accepting cycle 0) in which done pulses.
    function automatic int ref_done_cycle(input logic [DW-1:0] d);
`ifdef POPCOUNT_EARLY_EXIT_EN
        int hi = -1;
        for (int k = 0; k < NCHUNK; k++)
            if (((d >> (7 * k)) & 28'h7F) != 0) hi = k;
        return ((hi + 1 < 1) ? 1 : hi + 1) + 1;
`else
        return NCHUNK + 1;
`endif
    endfunction

    // One full transaction: start in cycle 0, then check every cycle up to
    // and including the cycle after done. Optionally holds start high with
    // all-ones data during the run to prove it is ignored.
    task automatic run_one(input logic [DW-1:0] d, input int exp_cnt, input bit hold_start);
        int lat = ref_done_cycle(d);
        int done_seen = -1;
        @(negedge clk);
        chk("ready_before_start", int'(ready), 1);
        start   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
        start   = hold_start;
        data_in = hold_start ? 28'hFFFFFFF : 28'h0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", c), int'(busy), int'(c < lat));
            chk($sformatf("done_c%0d", c), int'(done), int'(c == lat));
            chk($sformatf("ready_c%0d", c), int'(ready), int'(c == lat + 1));
            chk($sformatf("count_c%0d", c), int'(count), (c < lat) ? model_count : exp_cnt);
            if (done && done_seen < 0) done_seen = c;
        end
        start = 1'b0;
        model_count = exp_cnt;
        $display("txn data=%07h count=%0d exp=%0d done_cycle=%0d exp_cycle=%0d hold=%0d",
                 d, count, exp_cnt, done_seen, lat, hold_start);
    endtask

    vec_t vecs[$];

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;

        // Test 1: reset held two cycles.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_count", int'(count), 0);
        $display("txn reset ready=%0d busy=%0d done=%0d count=%0d", ready, busy, done, count);

        // Tests 2, 3, 4 and extra patterns, table-driven.
        vecs.push_back('{28'hFFFFFFF, 28, 1'b0});
        vecs.push_back('{28'h0000001,  1, 1'b0});
        vecs.push_back('{28'h8000000,  1, 1'b0});
        vecs.push_back('{28'h5555555, 14, 1'b0});
        vecs.push_back('{28'h0000000,  0, 1'b0});
        vecs.push_back('{28'h000007F,  7, 1'b1});
        vecs.push_back('{28'h0003F80,  7, 1'b0});
        vecs.push_back('{28'hFFFFFFF, 28, 1'b0});
        foreach (vecs[i]) run_one(vecs[i].data, vecs[i].exp_count, vecs[i].hold_start);

        // Test 5: reset in cycle 2 of a run.
        @(negedge clk);
        start   = 1'b1;
        data_in = 28'hFFFFFFF;
        @(posedge clk);            // cycle 0 accepted
        #1 start = 1'b0;
        @(posedge clk);            // into cycle 2
        #1 rst = 1'b1;
        @(posedge clk);            // into cycle 3
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_busy",  int'(busy),  0);
        chk("midrst_count", int'(count), 0);
        for (int c = 0; c < NCHUNK + 2; c++) begin
            chk($sformatf("midrst_nodone_%0d", c), int'(done), 0);
            @(negedge clk);
        end
        $display("txn mid-run reset count=%0d ready=%0d", count, ready);
        model_count = 0;
        run_one(28'h00000FF, 8, 1'b0);

        // Randomized runs against the reference model; sparse data exercises
        // varying highest-nonzero-chunk positions.
        for (int r = 0; r < 30; r++) begin
            logic [DW-1:0] d;
            int nchunks;
            d = DW'($urandom);
            nchunks = $urandom_range(0, NCHUNK);
            d = (nchunks == NCHUNK) ? d : (d & ((28'h1 << (7 * nchunks)) - 28'h1));
            run_one(d, ref_ones(d), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
